// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file for the RV32I decode stage.
// Reads use a captured (registered) address with combinational data; x0 is
// hardwired to zero. A per-register pending bit tracks in-flight producers for
// hazard detection, with a registered population count.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data (and clear busy) onto read ports whose captured address matches.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_ce_read,
  input  logic [NRP*AW-1:0]   i_rd_addr,
  output logic [NRP*XLEN-1:0] o_rd_data,
  output logic [NRP-1:0]      o_busy,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_addr,
  input  logic                i_flush,
  output logic [AW:0]         o_pending_cnt
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_ok, alloc_ok;
  logic             cnt_inc, cnt_dec;

  // Writes and allocations aimed at x0 are dropped everywhere.
  assign wr_ok    = i_wr_en && (i_wr_addr != '0);
  assign alloc_ok = i_alloc_en && (i_alloc_addr != '0);

  // Register storage; entry 0 is only ever reset, so it folds to constant zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Count delta: a fresh alloc adds one, a writeback retiring a pending
  // register removes one unless a same-register alloc re-arms it.
  assign cnt_inc = alloc_ok && !pend_q[i_alloc_addr];
  assign cnt_dec = wr_ok && pend_q[i_wr_addr] &&
                   !(alloc_ok && (i_alloc_addr == i_wr_addr));

  // Next pending set: flush wins; otherwise alloc set overrides writeback clear.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) begin
        pend_d[i_wr_addr] = 1'b0;
      end
      if (alloc_ok) begin
        pend_d[i_alloc_addr] = 1'b1;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_pending_cnt = cnt_q;

  for (genvar gi = 0; gi < NRP; gi++) begin : g_port
    logic [AW-1:0]   raddr_q;
    logic [AW-1:0]   raddr_d;
    logic [XLEN-1:0] rd_data;
    logic            busy;

    // Hold the captured address while the read stage is stalled.
    assign raddr_d = i_ce_read ? i_rd_addr[gi*AW +: AW] : raddr_q;

    // Captured read address for this port.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        raddr_q <= '0;
      end else begin
        raddr_q <= raddr_d;
      end
    end

    // Read mux with x0 forced to zero and optional same-cycle forwarding.
    always_comb begin
      rd_data = (raddr_q == '0) ? '0 : mem_q[raddr_q];
      busy    = pend_q[raddr_q];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (i_wr_addr == raddr_q)) begin
        rd_data = i_wr_data;
        busy    = alloc_ok && (i_alloc_addr == raddr_q);
      end
`endif
    end

    assign o_rd_data[gi*XLEN +: XLEN] = rd_data;
    assign o_busy[gi]                 = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: a behavioural model predicts each cycle's outputs,
// the driver queues the prediction, and a negedge monitor compares.
// A second instance (NRP=4, DEPTH=16, XLEN=64) gets a short directed check.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: default parameters ----------------
  logic        rstn;
  logic        ce_read;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;
  logic [5:0]  pend_cnt;

  regfile_mp dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_ce_read(ce_read), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_busy(busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
    .i_flush(flush), .o_pending_cnt(pend_cnt)
  );

  // ---------------- instance B: parameter sweep ----------------
  logic         b_rstn;
  logic         b_ce_read;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_busy;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_alloc_en;
  logic [3:0]   b_alloc_addr;
  logic         b_flush;
  logic [4:0]   b_pend_cnt;

  regfile_mp #(.XLEN(64), .DEPTH(16), .NRP(4)) dut_b (
    .i_clk(clk), .i_rstn(b_rstn), .i_ce_read(b_ce_read), .i_rd_addr(b_rd_addr),
    .o_rd_data(b_rd_data), .o_busy(b_busy), .i_wr_en(b_wr_en),
    .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_alloc_en(b_alloc_en),
    .i_alloc_addr(b_alloc_addr), .i_flush(b_flush), .o_pending_cnt(b_pend_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  logic [31:0] m_mem [32];
  logic [4:0]  m_raddr [2];
  bit          m_pend [32];

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_raddr[0] = '0;
    m_raddr[1] = '0;
  endtask

  // Architectural effect of one rising edge given the inputs held across it.
  task automatic model_edge();
    if (rstn) begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (ce_read) begin
        m_raddr[0] = rd_addr[4:0];
        m_raddr[1] = rd_addr[9:5];
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (wr_en && wr_addr != 0) m_pend[wr_addr] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
      end
    end
  endtask

  // Predict outputs from model state plus the inputs currently driven.
  task automatic push_exp();
    exp_t e;
    logic [31:0] d [2];
    logic [1:0]  b;
    int cnt;
    cnt = 0;
    for (int i = 1; i < 32; i++) if (m_pend[i]) cnt++;
    for (int p = 0; p < 2; p++) begin
      d[p] = (m_raddr[p] == 0) ? 32'h0 : m_mem[m_raddr[p]];
      b[p] = (m_raddr[p] == 0) ? 1'b0 : m_pend[m_raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (rstn && wr_en && wr_addr != 0 && wr_addr == m_raddr[p]) begin
        d[p] = wr_data;
        b[p] = alloc_en && (alloc_addr == m_raddr[p]);
      end
`endif
    end
    e.d0 = d[0];
    e.d1 = d[1];
    e.busy = b;
    e.cnt = 6'(cnt);
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus on instance A.
  task automatic cyc(input logic ce, input logic [4:0] r0, input logic [4:0] r1,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ae, input logic [4:0] aa, input logic fl);
    @(posedge clk);
    model_edge();
    #1;
    rstn = 1'b1;
    ce_read = ce; rd_addr = {r1, r0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = ae; alloc_addr = aa; flush = fl;
    push_exp();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  // Assert reset away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #1;
    rstn = 1'b0;
    model_clear();
    push_exp();
  endtask

  // Monitor: compare every queued prediction against the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_txn++;
      chk("rd_data0", {32'h0, rd_data[31:0]},  {32'h0, mon_e.d0});
      chk("rd_data1", {32'h0, rd_data[63:32]}, {32'h0, mon_e.d1});
      chk("busy",     {62'h0, busy},           {62'h0, mon_e.busy});
      chk("pend_cnt", {58'h0, pend_cnt},       {58'h0, mon_e.cnt});
      $display("txn %0d: rd0=%h rd1=%h busy=%b cnt=%0d", n_txn,
               rd_data[31:0], rd_data[63:32], busy, pend_cnt);
    end
  end

  function automatic logic [63:0] val_b(input int i);
    logic [31:0] hi, lo;
    hi = 32'hCAFE_0000 + 32'(i);
    lo = 32'(i * i) ^ 32'h5A5A_5A5A;
    return {hi, lo};
  endfunction

  initial begin
    logic [3:0] b_ra [4];
    logic [4:0] r0, r1, wa, aa;

    rstn = 1'b0; ce_read = 0; rd_addr = '0; wr_en = 0; wr_addr = '0;
    wr_data = '0; alloc_en = 0; alloc_addr = '0; flush = 0;
    b_rstn = 1'b0; b_ce_read = 0; b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0;
    b_wr_data = '0; b_alloc_en = 0; b_alloc_addr = '0; b_flush = 0;
    model_clear();

    // Reset state.
    do_reset();
    do_reset();

    // Basic write/read, x0 stays zero.
    cyc(0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0);
    cyc(1, 5'd3, 5'd0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc(1, 5'd0, 5'd3, 1, 5'd0, 32'h0000_1234, 0, 0, 0);
    idle();

    // Stall hold: capture x7 then change address with ce low.
    cyc(0, 0, 0, 1, 5'd7, 32'h0000_0011, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd8, 32'h0000_0022, 0, 0, 0);
    cyc(1, 5'd7, 5'd8, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 5'd8, 5'd7, 0, 0, 0, 0, 0, 0);

    // Scoreboard: alloc 4, 9, 4; retire 4; alloc+write 9; flush.
    cyc(1, 5'd9, 5'd4, 0, 0, 0, 1, 5'd4, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
    cyc(0, 0, 0, 1, 5'd4, 32'h4444_0004, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd9, 32'h9999_0009, 1, 5'd9, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Same-cycle write to a captured register.
    cyc(1, 5'd6, 5'd6, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd6, 32'hA5A5_A5A5, 0, 0, 0);
    idle();

    // Mid-run reset after writes and allocs, then read x5.
    cyc(0, 0, 0, 1, 5'd5, 32'h5555_0005, 1, 5'd5, 0);
    cyc(1, 5'd5, 5'd3, 1, 5'd2, 32'h2222_0002, 1, 5'd2, 0);
    idle();
    do_reset();
    cyc(1, 5'd5, 5'd3, 0, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      r0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wa = 5'($urandom_range(0, 7));
      aa = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), r0, r1, 1'($urandom_range(0, 1)), wa, $urandom(),
            1'($urandom_range(0, 1)), aa, ($urandom_range(0, 19) == 0));
      end
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Instance B: four ports, 64-bit data, 16 registers.
    @(posedge clk); #1;
    b_rstn = 1'b1;
    for (int i = 1; i < 16; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = val_b(i);
      @(posedge clk); #1;
    end
    b_wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      b_alloc_en = 1'b1; b_alloc_addr = 4'(i);
      @(posedge clk); #1;
    end
    b_alloc_addr = 4'd3;
    @(posedge clk); #1;
    b_alloc_en = 1'b0;
    b_ra[0] = 4'd2; b_ra[1] = 4'd15; b_ra[2] = 4'd0; b_ra[3] = 4'd9;
    b_ce_read = 1'b1;
    b_rd_addr = {b_ra[3], b_ra[2], b_ra[1], b_ra[0]};
    @(posedge clk); #1;
    b_ce_read = 1'b0;
    b_rd_addr = '1;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_rd_data%0d", p), b_rd_data[p*64 +: 64],
          (b_ra[p] == 0) ? 64'h0 : val_b(int'(b_ra[p])));
      chk($sformatf("b_busy%0d", p), {63'h0, b_busy[p]}, {63'h0, (b_ra[p] != 0)});
    end
    chk("b_pend_cnt_full", {59'h0, b_pend_cnt}, 64'd15);
    @(posedge clk); #1;
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    @(negedge clk);
    chk("b_pend_cnt_flush", {59'h0, b_pend_cnt}, 64'd0);
    chk("b_busy_flush", {60'h0, b_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RV32I pipeline. It replaces the fixed two-read, one-write base register file in the decode stage. It keeps synchronous-address, asynchronous-data reads gated by a read clock enable, with register 0 hardwired to zero. It adds a per-register pending-write scoreboard for hazard detection and an optional write-to-read bypass.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 4. AW = $clog2(DEPTH).
- NRP, 2, number of read ports, 1 to 4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_ce_read  in  1  read enable; when high, all read addresses are captured.
- i_rd_addr  in  NRP*AW  read addresses; port p occupies bits [p*AW +: AW].
- o_rd_data  out  NRP*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- o_busy  out  NRP  port p's captured register has a pending write.
- i_wr_en  in  1  write enable, writeback stage.
- i_wr_addr  in  AW  write address.
- i_wr_data  in  XLEN  write data.
- i_alloc_en  in  1  mark a destination register pending at issue.
- i_alloc_addr  in  AW  register to mark pending.
- i_flush  in  1  synchronously clear all pending bits.
- o_pending_cnt  out  AW+1  number of registers currently pending.

## Operation
- Storage covers registers 1..DEPTH-1. Register 0 always reads 0, is never written and is never pending.
- Write: on a rising edge with i_wr_en=1 and i_wr_addr≠0, mem[i_wr_addr] <= i_wr_data.
- Read address capture: on a rising edge with i_ce_read=1, raddr_q[p] <= i_rd_addr[p]. With i_ce_read=0 the captured addresses hold, so a stalled stage keeps its operands.
- Read data: o_rd_data[p] is combinational from raddr_q[p]. It is 0 when raddr_q[p]=0, otherwise mem[raddr_q[p]].
- Scoreboard: one pending bit per register, pend[1..DEPTH-1]. Per rising edge, in priority order:
  - i_flush=1 clears every bit. Alloc and write are ignored for scoreboard purposes that cycle; the memory write still occurs.
  - Otherwise, i_alloc_en with i_alloc_addr≠0 sets pend[i_alloc_addr].
  - Otherwise, a write with i_wr_addr≠0 clears pend[i_wr_addr].
  - Alloc and write to the same register in the same cycle leave the bit set, because the newer producer wins.
  - Alloc to a register that is already pending is legal. The bit stays set and the count does not change.
- o_busy[p] = pend[raddr_q[p]], combinational; it is 0 for register 0.
- o_pending_cnt is a registered population count of pend. It is updated with a +1/-1/0 delta each cycle and reset to 0 on flush. It never exceeds DEPTH-1.

## Timing
- Reset (i_rstn=0, asynchronous) sets:
  - all mem entries, raddr_q and pend to 0;
  - o_rd_data to all zeros, o_busy to 0 and o_pending_cnt to 0.
- Read latency: the address is presented at edge N with i_ce_read=1; data is valid combinationally after edge N, throughout cycle N+1.
- Write latency: without bypass, a write at edge N is visible on a read port from cycle N+1. A read port whose captured address equals a write issued in the same cycle shows the old value until that edge.
- Scoreboard latency: a pend change at edge N is visible on o_busy and o_pending_cnt after edge N.
- When reset is deasserted mid-operation, the first write or alloc after deassertion is accepted on the next rising edge.

## Configuration
- Macro REGFILE_BYPASS_EN.
  - Defined: when i_wr_en=1, i_wr_addr≠0 and i_wr_addr==raddr_q[p], o_rd_data[p] = i_wr_data combinationally in the same cycle. In that case o_busy[p] is also forced 0 that cycle, unless i_alloc_en targets the same register.
  - Undefined: there is no forwarding; the timing rules above apply unmodified.

## Test plan
- Reset: drive i_rstn low mid-run after several writes -> o_rd_data=0, o_busy=0 and o_pending_cnt=0 immediately, and reading x5 after reset returns 0.
- Basic read/write: write x3=0xDEADBEEF, then read x3 on port 0 and x0 on port 1 at the next edge -> port0=0xDEADBEEF and port1=0. A write to x0 with 0x1234 -> x0 still reads 0.
- Stall hold: capture x7 (holding 0x11), drop i_ce_read, change i_rd_addr to x8 -> o_rd_data stays 0x11 for 3 cycles.
- Scoreboard: alloc x4, x9, x4 on consecutive edges -> o_pending_cnt=1,2,2. Write x4 -> count 1, and o_busy is low for a port reading x4. Alloc x9 and write x9 in the same cycle -> x9 stays pending and the count stays 1. Flush -> count 0.
- Same-cycle write/read: with port 0 holding x6, write x6=0xA5A5A5A5 -> with REGFILE_BYPASS_EN, 0xA5A5A5A5 appears that cycle; without it, it appears the next cycle.
- Parameter sweep: NRP=4, DEPTH=16, XLEN=64 -> four independent ports return their own registers, and o_pending_cnt saturates at 15 after allocating x1..x15.
